alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Multi-cycle sequencer that runs one ALU operation against internal RAM. It reads up to two operands from RAM, drives `alu_core`, writes one or two results back, and pulses the PSW flag update in `sfr_regfile`. It sits between the instruction decoder and the RAM/ALU/SFR datapath in the 8051 core. It owns the RAM port and the ALU operand inputs while an operation is in flight.

## Interface
Parameters:
- `B_ADDR`, default 8'hF0: direct address of the B register, the target of the second result.

Ports:
- `clock`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  1: decoder presents an operation.
- `req_ready`  out  1: high only in IDLE; an operation is accepted when `req_valid & req_ready`.
- `req_alu_op`  in  5: ALU opcode, passed to the ALU unchanged.
- `req_src1_addr`  in  8: RAM address of operand 1.
- `req_src2_addr`  in  8: RAM address of operand 2.
- `req_src2_imm`  in  1: 1 means operand 2 is `req_imm` and no RAM read is issued.
- `req_imm`  in  8: immediate operand.
- `req_dst_addr`  in  8: RAM address for result 1.
- `req_no_wb`  in  1: 1 means flags only, with no write of result 1 (CJNE-style).
- `req_wb2`  in  1: 1 means result 2 is written to `B_ADDR` (MUL/DIV).
- `ram_addr`  out  8: RAM address.
- `ram_rd`  out  1: read strobe; `ram_rdata` is valid the cycle after.
- `ram_wr`  out  1: write strobe.
- `ram_wdata`  out  8: write data.
- `ram_rdata`  in  8: RAM read data.
- `alu_opcode`  out  5: to the ALU.
- `alu_op1`  out  8: to the ALU.
- `alu_op2`  out  8: to the ALU.
- `alu_res1`  in  8: combinational ALU result 1.
- `alu_res2`  in  8: combinational ALU result 2.
- `alu_cy`  in  1: ALU carry flag.
- `alu_ac`  in  1: ALU auxiliary carry flag.
- `alu_ov`  in  1: ALU overflow flag.
- `psw_set`  out  1: one-cycle pulse that makes the SFR file load `cy_out`, `ac_out` and `ov_out`.
- `cy_out`  out  1: registered carry flag.
- `ac_out`  out  1: registered auxiliary carry flag.
- `ov_out`  out  1: registered overflow flag.
- `done`  out  1: one-cycle pulse on the last cycle of an operation.

## Operation
- State machine: IDLE, RD1, RD2, EXEC, WB1, WB2.
- **IDLE**
  - `req_ready=1`.
  - On accept, latch all `req_*` fields and go to RD1.
- **RD1**
  - `ram_rd=1`, `ram_addr=src1`.
  - Next state: RD2.
- **RD2**
  - Capture `ram_rdata` into op1.
  - If `!src2_imm`: `ram_rd=1`, `ram_addr=src2`. If `src2_imm`: no strobe.
  - Next state: EXEC.
- **EXEC**
  - Capture op2: `ram_rdata` or the immediate.
  - Drive `alu_opcode`/`alu_op1`/`alu_op2` from the latched fields. The op2 driven to the ALU this cycle is the captured value, passed through combinationally.
  - Register `alu_res1`, `alu_res2`, `alu_cy`, `alu_ac`, `alu_ov`.
  - Next state: WB1.
- **WB1**
  - `psw_set=1`.
  - If `!no_wb`: `ram_wr=1`, `ram_addr=dst`, `ram_wdata=res1`.
  - If `!wb2`: `done=1` and go to IDLE. Otherwise go to WB2.
- **WB2**
  - `ram_wr=1`, `ram_addr=B_ADDR`, `ram_wdata=res2`, `done=1`.
  - Next state: IDLE.
- Outside EXEC, the ALU inputs hold their last values. There is no glitching on idle.
- `ram_rd` and `ram_wr` are never high in the same cycle.

## Timing
- Reset values:
  - State IDLE, `req_ready=1`.
  - All strobes (`ram_rd`, `ram_wr`, `psw_set`, `done`) are 0.
  - `ram_addr`, `ram_wdata`, `alu_*` outputs and `cy_out`/`ac_out`/`ov_out` are 0.
- Latency, counted from the accept edge:
  - 4 cycles with `wb2=0` (RD1, RD2, EXEC, WB1).
  - 5 cycles with `wb2=1`.
  - Latency is independent of `src2_imm` and `no_wb`.
- `done` is coincident with the final write or flag pulse. `req_ready` rises the following cycle, so back-to-back accept is possible with one idle cycle between operations.
- `req_*` inputs are ignored outside IDLE. A `req_valid` held high during an operation is not accepted until IDLE.
- Addresses are plain 8-bit with no wrap logic. `src1==dst` is legal, because the read completes before the write.
- `dst==B_ADDR` with `wb2=1` is legal: the WB2 write wins.
- Reset mid-operation:
  - Returns to IDLE on the next edge.
  - Pending writes and `psw_set` are dropped.
  - No `done` is issued.

## Structure
- The shared package `cpu_pkg` holds:
  - the state enum;
  - the ALU opcode constants (`ALU_ADD`, `ALU_MUL`, and the others);
  - `B_ADDR_DEFAULT = 8'hF0`.
- The block is a single flat FSM module. A sub-module is not natural.

## Test plan
- ADD from RAM: RAM[0x30]=0x7F, RAM[0x31]=0x01, ALU model gives 0x80 with ov=1, dst=0x32 → reads at 0x30 then 0x31; cycle 4 writes 0x80 to 0x32 with `psw_set=1`, `ov_out=1`, `done=1`.
- Immediate with no writeback: src1 at 0x40=0x05, imm=0x05, `no_wb=1` → only one `ram_rd`; cycle 4 has `psw_set=1`, `ram_wr=0`, `done=1`.
- MUL with `wb2`: op1=0x10, op2=0x20, ALU gives res1=0x00 and res2=0x02 → cycle 4 writes 0x00 to dst; cycle 5 writes 0x02 to 0xF0 with `done=1`; `psw_set` is high in cycle 4 only.
- Back-to-back: `req_valid` held high for two operations → second accept occurs the cycle after the first `done`; no strobe overlap.
- Reset asserted in EXEC → next cycle IDLE, no `ram_wr`, no `psw_set`, no `done`; a following request completes normally.
- Request held during a busy period with changing fields → only values present at accept are used.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared 8051 core definitions: sequencer state encoding, ALU opcodes and
// the fixed SFR address of the B register.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD1  = 3'd1,
    ST_RD2  = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB1  = 3'd4,
    ST_WB2  = 3'd5
  } seq_state_t;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_ANL  = 5'd2;
  localparam logic [4:0] ALU_ORL  = 5'd3;
  localparam logic [4:0] ALU_XRL  = 5'd4;
  localparam logic [4:0] ALU_MUL  = 5'd5;
  localparam logic [4:0] ALU_DIV  = 5'd6;
  localparam logic [4:0] ALU_CJNE = 5'd7;

  localparam logic [7:0] B_ADDR_DEFAULT = 8'hF0;

endpackage

// File: rtl/alu_op_sequencer.sv
// Runs one ALU operation against internal RAM: read up to two operands,
// execute, write one or two results back and pulse the PSW flag load.
//
// Handshake: an operation is accepted on a rising edge where
// req_valid & req_ready; req_ready is high only in IDLE, and all req_*
// fields are sampled on that edge and ignored at every other time.
module alu_op_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0] B_ADDR = B_ADDR_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_alu_op,
  input  logic [7:0] req_src1_addr,
  input  logic [7:0] req_src2_addr,
  input  logic       req_src2_imm,
  input  logic [7:0] req_imm,
  input  logic [7:0] req_dst_addr,
  input  logic       req_no_wb,
  input  logic       req_wb2,
  output logic [7:0] ram_addr,
  output logic       ram_rd,
  output logic       ram_wr,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata,
  output logic [4:0] alu_opcode,
  output logic [7:0] alu_op1,
  output logic [7:0] alu_op2,
  input  logic [7:0] alu_res1,
  input  logic [7:0] alu_res2,
  input  logic       alu_cy,
  input  logic       alu_ac,
  input  logic       alu_ov,
  output logic       psw_set,
  output logic       cy_out,
  output logic       ac_out,
  output logic       ov_out,
  output logic       done,
  output seq_state_t dbg_state
);

  seq_state_t state, state_next;

  logic [4:0] op_r;
  logic [7:0] src1_r, src2_r, imm_r, dst_r;
  logic       imm_sel_r, no_wb_r, wb2_r;
  logic [7:0] op1_r;
  logic [7:0] res1_r, res2_r;
  logic [4:0] opcode_h;
  logic [7:0] op1_h, op2_h;
  logic [7:0] op2_cap;

  assign op2_cap   = imm_sel_r ? imm_r : ram_rdata;
  assign dbg_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      op_r      <= '0;
      src1_r    <= '0;
      src2_r    <= '0;
      imm_r     <= '0;
      dst_r     <= '0;
      imm_sel_r <= 1'b0;
      no_wb_r   <= 1'b0;
      wb2_r     <= 1'b0;
      op1_r     <= '0;
      res1_r    <= '0;
      res2_r    <= '0;
      cy_out    <= 1'b0;
      ac_out    <= 1'b0;
      ov_out    <= 1'b0;
      opcode_h  <= '0;
      op1_h     <= '0;
      op2_h     <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && req_valid) begin
        op_r      <= req_alu_op;
        src1_r    <= req_src1_addr;
        src2_r    <= req_src2_addr;
        imm_sel_r <= req_src2_imm;
        imm_r     <= req_imm;
        dst_r     <= req_dst_addr;
        no_wb_r   <= req_no_wb;
        wb2_r     <= req_wb2;
      end
      if (state == ST_RD2) begin
        op1_r <= ram_rdata;
      end
      // The hold copies keep the ALU inputs stable after EXEC until the next op.
      if (state == ST_EXEC) begin
        res1_r   <= alu_res1;
        res2_r   <= alu_res2;
        cy_out   <= alu_cy;
        ac_out   <= alu_ac;
        ov_out   <= alu_ov;
        opcode_h <= op_r;
        op1_h    <= op1_r;
        op2_h    <= op2_cap;
      end
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    ram_rd     = 1'b0;
    ram_wr     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;
    psw_set    = 1'b0;
    done       = 1'b0;
    alu_opcode = opcode_h;
    alu_op1    = op1_h;
    alu_op2    = op2_h;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ST_RD1;
      end
      ST_RD1: begin
        ram_rd     = 1'b1;
        ram_addr   = src1_r;
        state_next = ST_RD2;
      end
      ST_RD2: begin
        if (!imm_sel_r) begin
          ram_rd   = 1'b1;
          ram_addr = src2_r;
        end
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        alu_opcode = op_r;
        alu_op1    = op1_r;
        alu_op2    = op2_cap;
        state_next = ST_WB1;
      end
      ST_WB1: begin
        psw_set = 1'b1;
        if (!no_wb_r) begin
          ram_wr    = 1'b1;
          ram_addr  = dst_r;
          ram_wdata = res1_r;
        end
        if (wb2_r) begin
          state_next = ST_WB2;
        end else begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_WB2: begin
        ram_wr     = 1'b1;
        ram_addr   = B_ADDR;
        ram_wdata  = res2_r;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: RAM and ALU environment models, a transaction
// level reference that predicts every cycle's strobes, and random operations.
module tb_alu_op_sequencer;
  import cpu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       req_valid, req_ready, req_src2_imm, req_no_wb, req_wb2;
  logic [4:0] req_alu_op;
  logic [7:0] req_src1_addr, req_src2_addr, req_imm, req_dst_addr;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic       ram_rd, ram_wr;
  logic [4:0] alu_opcode;
  logic [7:0] alu_op1, alu_op2, alu_res1, alu_res2;
  logic       alu_cy, alu_ac, alu_ov;
  logic       psw_set, cy_out, ac_out, ov_out, done;
  seq_state_t dbg_state;

  alu_op_sequencer dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_alu_op(req_alu_op),
    .req_src1_addr(req_src1_addr), .req_src2_addr(req_src2_addr),
    .req_src2_imm(req_src2_imm), .req_imm(req_imm), .req_dst_addr(req_dst_addr),
    .req_no_wb(req_no_wb), .req_wb2(req_wb2),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_res1(alu_res1), .alu_res2(alu_res2),
    .alu_cy(alu_cy), .alu_ac(alu_ac), .alu_ov(alu_ov),
    .psw_set(psw_set), .cy_out(cy_out), .ac_out(ac_out), .ov_out(ov_out),
    .done(done), .dbg_state(dbg_state)
  );

  // ---------------- ALU behaviour: {res1, res2, cy, ac, ov} ----------------
  function automatic logic [18:0] alu_ref(input logic [4:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    int x;
    logic [7:0] r1, r2;
    logic cy, ac, ov;
    r1 = 8'h00; r2 = 8'h00; cy = 1'b0; ac = 1'b0; ov = 1'b0; x = 0;
    case (op)
      ALU_ADD: begin
        x  = int'(a) + int'(b);
        r1 = x[7:0];
        cy = (x > 255);
        ac = ((int'(a % 16) + int'(b % 16)) > 15);
        ov = (a[7] == b[7]) && (r1[7] != a[7]);
      end
      ALU_SUB: begin
        x  = int'(a) - int'(b);
        r1 = x[7:0];
        cy = (a < b);
        ac = ((a % 16) < (b % 16));
        ov = (a[7] != b[7]) && (r1[7] != a[7]);
      end
      ALU_ANL: r1 = a & b;
      ALU_ORL: r1 = a | b;
      ALU_XRL: r1 = a ^ b;
      ALU_MUL: begin
        x  = int'(a) * int'(b);
        r1 = x[7:0];
        r2 = x[15:8];
        ov = (x > 255);
      end
      ALU_DIV: begin
        if (b == 8'h00) ov = 1'b1;
        else begin
          r1 = a / b;
          r2 = a % b;
        end
      end
      ALU_CJNE: begin
        r1 = a;
        cy = (a < b);
      end
      default: r1 = 8'h00;
    endcase
    return {r1, r2, cy, ac, ov};
  endfunction

  always_comb {alu_res1, alu_res2, alu_cy, alu_ac, alu_ov} = alu_ref(alu_opcode, alu_op1, alu_op2);

  // ---------------- RAM environment with a bench-side load port ----------------
  logic [7:0] ram [256];
  logic       load_en = 1'b0;
  logic [7:0] load_addr = 8'h00, load_data = 8'h00;

  always @(posedge clock) begin
    if (load_en) ram[load_addr] <= load_data;
    else if (ram_wr) ram[ram_addr] <= ram_wdata;
    if (ram_rd) ram_rdata <= ram[ram_addr];
  end

  // ---------------- scoreboard ----------------
  logic [7:0]  ref_mem [256];
  logic [19:0] exp_q[$];
  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [7:0] addr, input logic [7:0] data);
    load_en = 1'b1; load_addr = addr; load_data = data;
    ref_mem[addr] = data;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  task automatic scramble_req();
    req_alu_op    = 5'($urandom_range(0, 31));
    req_src1_addr = 8'($urandom_range(0, 255));
    req_src2_addr = 8'($urandom_range(0, 255));
    req_src2_imm  = 1'($urandom_range(0, 1));
    req_imm       = 8'($urandom_range(0, 255));
    req_dst_addr  = 8'($urandom_range(0, 255));
    req_no_wb     = 1'($urandom_range(0, 1));
    req_wb2       = 1'($urandom_range(0, 1));
  endtask

  // One operation. hold keeps req_valid high afterwards (back-to-back);
  // rst_cyc > 0 asserts reset during that cycle of the operation.
  task automatic run_op(input logic [4:0] op, input logic [7:0] s1, input logic [7:0] s2,
                        input logic isel, input logic [7:0] imm, input logic [7:0] dst,
                        input logic nowb, input logic w2, input logic hold, input int rst_cyc);
    logic [7:0]  a, b, r1, r2;
    logic [18:0] r;
    logic [19:0] obs_w, exp_w;
    int n, waited;
    a  = ref_mem[s1];
    b  = isel ? imm : ref_mem[s2];
    r  = alu_ref(op, a, b);
    r1 = r[18:11];
    r2 = r[10:3];
    n  = w2 ? 5 : 4;
    exp_q.push_back({1'b1, 3'b000, s1, 8'h00});
    exp_q.push_back(isel ? 20'h0 : {1'b1, 3'b000, s2, 8'h00});
    exp_q.push_back(20'h0);
    exp_q.push_back({1'b0, !nowb, 1'b1, !w2, nowb ? 8'h00 : dst, nowb ? 8'h00 : r1});
    if (w2) exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b1, B_ADDR_DEFAULT, r2});

    req_alu_op = op; req_src1_addr = s1; req_src2_addr = s2; req_src2_imm = isel;
    req_imm = imm; req_dst_addr = dst; req_no_wb = nowb; req_wb2 = w2;
    req_valid = 1'b1;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    chk("accept_timeout", 32'(waited < 20), 32'd1);
    @(posedge clock);
    #1;
    req_valid = hold && (rst_cyc == 0);
    scramble_req();

    for (int c = 1; c <= n; c++) begin
      @(negedge clock);
      obs_w = {ram_rd, ram_wr, psw_set, done, (ram_rd | ram_wr) ? ram_addr : 8'h00,
               ram_wr ? ram_wdata : 8'h00};
      exp_w = exp_q.pop_front();
      chk($sformatf("trace_c%0d", c), obs_w, exp_w);
      chk("busy_ready", req_ready, 1'b0);
      if (c == 3) chk("alu_inputs_exec", {alu_opcode, alu_op1, alu_op2}, {op, a, b});
      if (c == 4) begin
        chk("flags", {cy_out, ac_out, ov_out}, r[2:0]);
        chk("alu_inputs_hold", {alu_opcode, alu_op1, alu_op2}, {op, a, b});
      end
      if (c == rst_cyc) begin
        reset = 1'b1;
        @(negedge clock);
        chk("reset_midop_idle", {req_ready, ram_rd, ram_wr, psw_set, done}, 5'b10000);
        chk("reset_midop_flags", {cy_out, ac_out, ov_out}, 3'b000);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clock);
          chk("after_reset_quiet", {ram_wr, psw_set, done}, 3'b000);
        end
        exp_q.delete();
        return;
      end
    end
    if (!nowb) ref_mem[dst] = r1;
    if (w2) ref_mem[B_ADDR_DEFAULT] = r2;
    @(negedge clock);
    chk("ready_after_done", {req_ready, done, ram_wr, psw_set}, 4'b1000);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    req_valid = 1'b0;
    scramble_req();
    @(negedge clock);
    for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom_range(0, 255)));
    chk("reset_ready", req_ready, 1'b1);
    chk("reset_strobes", {ram_rd, ram_wr, psw_set, done}, 4'b0000);
    chk("reset_ram_bus", {ram_addr, ram_wdata}, 16'h0000);
    chk("reset_alu_bus", {alu_opcode, alu_op1, alu_op2}, 21'h0);
    chk("reset_flags", {cy_out, ac_out, ov_out}, 3'b000);
    reset = 1'b0;
    @(negedge clock);

    // ADD 0x7F + 0x01 -> 0x80 with overflow
    poke(8'h30, 8'h7F); poke(8'h31, 8'h01);
    run_op(ALU_ADD, 8'h30, 8'h31, 1'b0, 8'h00, 8'h32, 1'b0, 1'b0, 1'b0, 0);
    chk("add_result_in_ram", ram[8'h32], 8'h80);
    chk("add_ov", ov_out, 1'b1);
    // compare against immediate, flags only
    poke(8'h40, 8'h05);
    run_op(ALU_CJNE, 8'h40, 8'h41, 1'b1, 8'h05, 8'h42, 1'b1, 1'b0, 1'b0, 0);
    // MUL with second result to B
    poke(8'h50, 8'h10); poke(8'h51, 8'h20);
    run_op(ALU_MUL, 8'h50, 8'h51, 1'b0, 8'h00, 8'h52, 1'b0, 1'b1, 1'b0, 0);
    chk("mul_b_reg", ram[8'hF0], 8'h02);
    // DIV writing result 1 to B as well: the B write must win
    poke(8'h60, 8'h64); poke(8'h61, 8'h07);
    run_op(ALU_DIV, 8'h60, 8'h61, 1'b0, 8'h00, 8'hF0, 1'b0, 1'b1, 1'b0, 0);
    chk("dst_is_b_wb2_wins", ram[8'hF0], 8'h02);
    // src1 == dst, back-to-back with req_valid held
    run_op(ALU_SUB, 8'h70, 8'h71, 1'b0, 8'h00, 8'h70, 1'b0, 1'b0, 1'b1, 0);
    run_op(ALU_XRL, 8'h70, 8'h72, 1'b1, 8'hA5, 8'h73, 1'b0, 1'b1, 1'b1, 0);
    run_op(ALU_ADD, 8'h73, 8'h70, 1'b0, 8'h00, 8'h74, 1'b0, 1'b0, 1'b0, 0);
    // reset asserted in EXEC, then a normal operation
    run_op(ALU_ADD, 8'h30, 8'h31, 1'b0, 8'h00, 8'h80, 1'b0, 1'b1, 1'b0, 3);
    run_op(ALU_ORL, 8'h30, 8'h31, 1'b0, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0, 0);

    for (int t = 0; t < 40; t++) begin
      run_op(5'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             (t != 39) && ($urandom_range(0, 1) == 1), 0);
    end
    req_valid = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 256; i++) begin
      if (ram[i] !== ref_mem[i]) begin
        chk($sformatf("final_ram_%02h", i), ram[i], ref_mem[i]);
      end
    end
    chk("final_ram_b", ram[8'hF0], ref_mem[8'hF0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
